frame_buffer_ring_ctrl: RTL and testbench

Sequential controller for a ring of NUM_BUFFERS (2..4) external dual-port frame buffers in the GFG-MCU frame buffer system. It tracks which buffer is the rasterization target, which is being displayed, and which holds a completed frame awaiting display. Swaps are driven by rasterizer frame-done and display vsync handshakes. A clear engine fills each newly assigned raster buffer with a clear pixel before raster writes are accepted. Write port muxing into the buffers is done here; read muxing stays in the datapath.

---
 rtl/frame_buffer_ring_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_frame_buffer_ring_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ring_ctrl.sv
// Frame buffer ring controller.
// Tracks the raster target (R), the displayed buffer (D) and an optional
// completed-but-not-yet-displayed buffer (C) across a ring of external
// dual-port frame buffers. It clears each newly assigned raster buffer before
// accepting raster writes, and steers the single write port to the right buffer.
module frame_buffer_ring_ctrl #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int COLOR_DEPTH      = 12,
  parameter int Z_DEPTH          = 2,
  parameter int NUM_BUFFERS      = 3,
  parameter int CLEAR_ENABLE     = 1,
  parameter int CLEAR_COLOR      = 0,
  localparam int VAW = $clog2(VERT_RESOLUTION),
  localparam int HAW = $clog2(HORIZ_RESOLUTION),
  localparam int AW  = $clog2(VERT_RESOLUTION * HORIZ_RESOLUTION),
  localparam int DW  = COLOR_DEPTH + Z_DEPTH,
  localparam int BW  = (NUM_BUFFERS > 2) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   i_frame_done,
  input  logic                   i_vsync,
  input  logic                   i_rasterizer_write_en,
  input  logic [VAW-1:0]         i_rasterizer_vert_write_addr,
  input  logic [HAW-1:0]         i_rasterizer_horiz_write_addr,
  input  logic [DW-1:0]          i_rasterizer_write_pixel_data,
  output logic [NUM_BUFFERS-1:0] o_fb_write_en,
  output logic [AW-1:0]          o_fb_write_addr,
  output logic [DW-1:0]          o_fb_write_data,
  output logic [BW-1:0]          o_raster_target,
  output logic [BW-1:0]          o_display_source,
  output logic                   o_raster_ready,
  output logic                   o_swap,
  output logic [7:0]             o_drop_count
);

  // Clear word: requested colour, depth field at farthest (all ones).
  localparam logic [DW-1:0] CLEAR_WORD = {COLOR_DEPTH'(CLEAR_COLOR), {Z_DEPTH{1'b1}}};
  localparam logic [AW-1:0] CLEAR_LAST = AW'(VERT_RESOLUTION * HORIZ_RESOLUTION - 1);

  typedef enum logic [1:0] {
    ST_CLEAR      = 2'd0,
    ST_RASTER     = 2'd1,
    ST_WAIT_VSYNC = 2'd2   // double buffering only: frame done, waiting to flip
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   r_q, r_d;
  logic [BW-1:0]   d_q, d_d;
  logic [BW-1:0]   c_q, c_d;
  logic            c_valid_q, c_valid_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            swap_q, swap_d;
  logic [7:0]      drop_q, drop_d;

  logic [NUM_BUFFERS-1:0] r_onehot;
  logic [AW-1:0]          raster_addr;
  logic [7:0]             drop_inc;

  // Lowest buffer index that is neither of the two busy indices.
  function automatic logic [BW-1:0] lowest_free(input logic [BW-1:0] busy_a,
                                                input logic [BW-1:0] busy_b);
    logic [BW-1:0] pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (!found && BW'(i) != busy_a && BW'(i) != busy_b) begin
        pick  = BW'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign r_onehot    = NUM_BUFFERS'(1) << r_q;
  assign raster_addr = AW'(HORIZ_RESOLUTION) * AW'(i_rasterizer_vert_write_addr)
                     + AW'(i_rasterizer_horiz_write_addr);
  assign drop_inc    = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  // Next-state logic: clear sequencing, frame-done and vsync buffer rotation.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d   = state_q;
    r_d       = r_q;
    d_d       = d_q;
    c_d       = c_q;
    c_valid_d = c_valid_q;
    cnt_d     = cnt_q;
    swap_d    = 1'b0;
    drop_d    = drop_q;

    unique case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ENABLE == 0 || cnt_q == CLEAR_LAST) begin
          state_d = ST_RASTER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // A pending completed frame may still be shown while we clear.
        if (NUM_BUFFERS > 2 && i_vsync && c_valid_q) begin
          d_d       = c_q;
          c_valid_d = 1'b0;
          swap_d    = 1'b1;
        end
      end

      ST_RASTER: begin
        if (NUM_BUFFERS == 2) begin
          if (i_frame_done) state_d = ST_WAIT_VSYNC;
        end else if (i_frame_done) begin
          state_d = ST_CLEAR;
          if (c_valid_q) drop_d = drop_inc;
          if (i_vsync) begin
            // Finished frame goes straight to display; any older one is lost.
            d_d       = r_q;
            swap_d    = 1'b1;
            c_valid_d = 1'b0;
            r_d       = lowest_free(r_q, r_q);
          end else begin
            c_d       = r_q;
            c_valid_d = 1'b1;
            r_d       = lowest_free(d_q, r_q);
          end
        end else if (i_vsync && c_valid_q) begin
          d_d       = c_q;
          c_valid_d = 1'b0;
          swap_d    = 1'b1;
        end
      end

      ST_WAIT_VSYNC: begin
        if (i_vsync) begin
          d_d     = r_q;
          r_d     = d_q;
          swap_d  = 1'b1;
          state_d = ST_CLEAR;
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_sys_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order or of other always_ff blocks.
    if (i_sys_rst) begin
      state_q   <= ST_CLEAR;
      r_q       <= '0;
      d_q       <= BW'(1);
      c_q       <= '0;
      c_valid_q <= 1'b0;
      cnt_q     <= '0;
      swap_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      d_q       <= d_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      cnt_q     <= cnt_d;
      swap_q    <= swap_d;
      drop_q    <= drop_d;
    end
  end

  // Write port steering: clear engine in CLEAR, raster pass-through in RASTER.
  always_comb begin
    o_fb_write_en   = '0;
    o_fb_write_addr = raster_addr;
    o_fb_write_data = i_rasterizer_write_pixel_data;
    if (state_q == ST_CLEAR) begin
      o_fb_write_addr = cnt_q;
      o_fb_write_data = CLEAR_WORD;
      if (CLEAR_ENABLE != 0) o_fb_write_en = r_onehot;
    end else if (state_q == ST_RASTER && i_rasterizer_write_en) begin
      o_fb_write_en = r_onehot;
    end
  end

  assign o_raster_target  = r_q;
  assign o_display_source = d_q;
  assign o_raster_ready   = (state_q == ST_RASTER);
  assign o_swap           = swap_q;
  assign o_drop_count     = drop_q;

endmodule

// File: tb/tb_frame_buffer_ring_ctrl.sv
// Testbench for frame_buffer_ring_ctrl: three instances on shared stimulus
// (triple buffering, double buffering, quad buffering without clear), each
// tracked by an event-level reference model of the buffer ring.
module tb_frame_buffer_ring_ctrl;

  localparam int PIX = 6;          // 2 rows x 3 columns
  localparam int DW  = 14;
  localparam int NI  = 3;
  localparam int PH_CLEAR = 0, PH_DRAW = 1, PH_WAIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fd, vs, we;
  logic [0:0]    vert;
  logic [1:0]    horiz;
  logic [DW-1:0] din;

  logic [2:0] a_we;  logic [1:0] b_we;  logic [3:0] c_we;
  logic [2:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_data, b_data, c_data;
  logic [1:0] a_rt, a_ds, c_rt, c_ds;
  logic [0:0] b_rt, b_ds;
  logic a_rdy, b_rdy, c_rdy, a_sw, b_sw, c_sw;
  logic [7:0] a_dc, b_dc, c_dc;

  frame_buffer_ring_ctrl #(.VERT_RESOLUTION(2), .HORIZ_RESOLUTION(3), .COLOR_DEPTH(12),
    .Z_DEPTH(2), .NUM_BUFFERS(3), .CLEAR_ENABLE(1), .CLEAR_COLOR(12'hABC)) u_a (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_frame_done(fd), .i_vsync(vs),
    .i_rasterizer_write_en(we), .i_rasterizer_vert_write_addr(vert),
    .i_rasterizer_horiz_write_addr(horiz), .i_rasterizer_write_pixel_data(din),
    .o_fb_write_en(a_we), .o_fb_write_addr(a_addr), .o_fb_write_data(a_data),
    .o_raster_target(a_rt), .o_display_source(a_ds), .o_raster_ready(a_rdy),
    .o_swap(a_sw), .o_drop_count(a_dc));

  frame_buffer_ring_ctrl #(.VERT_RESOLUTION(2), .HORIZ_RESOLUTION(3), .COLOR_DEPTH(12),
    .Z_DEPTH(2), .NUM_BUFFERS(2), .CLEAR_ENABLE(1), .CLEAR_COLOR(12'h5A5)) u_b (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_frame_done(fd), .i_vsync(vs),
    .i_rasterizer_write_en(we), .i_rasterizer_vert_write_addr(vert),
    .i_rasterizer_horiz_write_addr(horiz), .i_rasterizer_write_pixel_data(din),
    .o_fb_write_en(b_we), .o_fb_write_addr(b_addr), .o_fb_write_data(b_data),
    .o_raster_target(b_rt), .o_display_source(b_ds), .o_raster_ready(b_rdy),
    .o_swap(b_sw), .o_drop_count(b_dc));

  frame_buffer_ring_ctrl #(.VERT_RESOLUTION(2), .HORIZ_RESOLUTION(3), .COLOR_DEPTH(12),
    .Z_DEPTH(2), .NUM_BUFFERS(4), .CLEAR_ENABLE(0), .CLEAR_COLOR(12'h123)) u_c (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_frame_done(fd), .i_vsync(vs),
    .i_rasterizer_write_en(we), .i_rasterizer_vert_write_addr(vert),
    .i_rasterizer_horiz_write_addr(horiz), .i_rasterizer_write_pixel_data(din),
    .o_fb_write_en(c_we), .o_fb_write_addr(c_addr), .o_fb_write_data(c_data),
    .o_raster_target(c_rt), .o_display_source(c_ds), .o_raster_ready(c_rdy),
    .o_swap(c_sw), .o_drop_count(c_dc));

  logic [3:0]    act_we   [NI];
  logic [2:0]    act_addr [NI];
  logic [DW-1:0] act_data [NI];
  logic [1:0]    act_r    [NI];
  logic [1:0]    act_d    [NI];
  logic          act_rdy  [NI];
  logic          act_swap [NI];
  logic [7:0]    act_drop [NI];

  assign act_we[0] = {1'b0, a_we};  assign act_we[1] = {2'b00, b_we};  assign act_we[2] = c_we;
  assign act_addr[0] = a_addr;  assign act_addr[1] = b_addr;  assign act_addr[2] = c_addr;
  assign act_data[0] = a_data;  assign act_data[1] = b_data;  assign act_data[2] = c_data;
  assign act_r[0] = a_rt;  assign act_r[1] = {1'b0, b_rt};  assign act_r[2] = c_rt;
  assign act_d[0] = a_ds;  assign act_d[1] = {1'b0, b_ds};  assign act_d[2] = c_ds;
  assign act_rdy[0] = a_rdy;  assign act_rdy[1] = b_rdy;  assign act_rdy[2] = c_rdy;
  assign act_swap[0] = a_sw;  assign act_swap[1] = b_sw;  assign act_swap[2] = c_sw;
  assign act_drop[0] = a_dc;  assign act_drop[1] = b_dc;  assign act_drop[2] = c_dc;

  // Reference model: ring of buffers seen as roles (drawing, showing, waiting).
  typedef struct {
    int n; int ce; int cc;
    int phase; int pos;
    int r; int d; int c; bit cv;
    bit swap; int drops;
  } mdl_t;

  mdl_t m [NI];
  int n_cmp = 0;
  int n_err = 0;

  function automatic mdl_t mdl_reset(mdl_t x);
    mdl_t y = x;
    y.phase = PH_CLEAR; y.pos = 0; y.r = 0; y.d = 1; y.c = 0; y.cv = 0;
    y.swap = 0; y.drops = 0;
    return y;
  endfunction

  function automatic int first_free(int n, int a, int b);
    for (int i = 0; i < n; i++) if (i != a && i != b) return i;
    return -1;
  endfunction

  function automatic mdl_t mdl_next(mdl_t x, bit r_in, bit f_in, bit v_in);
    mdl_t y = x;
    bit done_now;
    if (r_in) return mdl_reset(x);
    y.swap = 0;
    done_now = f_in && (x.phase == PH_DRAW);
    if (x.phase == PH_CLEAR) begin
      if (x.ce == 0 || x.pos == PIX - 1) begin y.phase = PH_DRAW; y.pos = 0; end
      else y.pos = x.pos + 1;
    end
    if (x.n == 2) begin
      if (done_now) y.phase = PH_WAIT;
      else if (x.phase == PH_WAIT && v_in) begin
        y.d = x.r; y.r = x.d; y.swap = 1; y.phase = PH_CLEAR;
      end
    end else if (done_now) begin
      if (x.cv && y.drops < 255) y.drops = x.drops + 1;
      y.phase = PH_CLEAR;
      if (v_in) begin
        y.d = x.r; y.swap = 1; y.cv = 0; y.r = first_free(x.n, x.r, x.r);
      end else begin
        y.c = x.r; y.cv = 1; y.r = first_free(x.n, x.d, x.r);
      end
    end else if (v_in && x.cv) begin
      y.d = x.c; y.cv = 0; y.swap = 1;
    end
    return y;
  endfunction

  function automatic int exp_we(mdl_t x, bit w);
    if (x.phase == PH_CLEAR) return (x.ce != 0) ? (1 << x.r) : 0;
    if (x.phase == PH_DRAW && w) return 1 << x.r;
    return 0;
  endfunction

  function automatic int exp_addr(mdl_t x, int v, int h);
    if (x.phase == PH_CLEAR) return x.pos;
    return (3 * v + h) % 8;
  endfunction

  function automatic int exp_data(mdl_t x, int dd);
    if (x.phase == PH_CLEAR) return ((x.cc & 'hFFF) << 2) | 3;
    return dd;
  endfunction

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < NI; k++) m[k] = mdl_next(m[k], rst, fd, vs);
    @(negedge clk);
  endtask

  task automatic set_in(bit r_v, bit f_v, bit v_v, bit w_v, int ve, int ho, int dd);
    rst = r_v; fd = f_v; vs = v_v; we = w_v;
    vert = 1'(ve); horiz = 2'(ho); din = DW'(dd);
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int i = 0;
    #1;
    while (act_rdy[0] !== 1'b1 && i < 40) begin advance(); #1; i++; end
    n_cmp++; if (act_rdy[0] !== 1'b1) begin n_err++; $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", act_rdy[0], i); end
  endtask

  task automatic pulse_fd(bit with_vsync);
    fd = 1'b1; vs = with_vsync; #1;
    advance();
    fd = 1'b0; vs = 1'b0;
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    advance(); advance();
    rst = 1'b0; #1;
    n_cmp++; if (act_r[0] !== 2'd0) begin n_err++; $display("FAIL rst_target: got %0d expected 0", act_r[0]); end
    n_cmp++; if (act_d[0] !== 2'd1) begin n_err++; $display("FAIL rst_display: got %0d expected 1", act_d[0]); end
    n_cmp++; if (act_rdy[0] !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", act_rdy[0]); end
    n_cmp++; if (act_swap[0] !== 1'b0) begin n_err++; $display("FAIL rst_swap: got %b expected 0", act_swap[0]); end
    n_cmp++; if (act_drop[0] !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d expected 0", act_drop[0]); end
    n_cmp++; if (act_d[1] !== 2'd1) begin n_err++; $display("FAIL rst_display_n2: got %0d expected 1", act_d[1]); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < PIX; i++) begin
      set_in(0, 0, 0, 1, 1, 2, 14'h1234); #1;
      n_cmp++; if (act_we[0] !== 4'b0001) begin n_err++; $display("FAIL clr_we[%0d]: got %b expected 0001", i, act_we[0]); end
      n_cmp++; if (act_addr[0] !== 3'(i)) begin n_err++; $display("FAIL clr_addr[%0d]: got %0d expected %0d", i, act_addr[0], i); end
      n_cmp++; if (act_data[0] !== 14'h2AF3) begin n_err++; $display("FAIL clr_data[%0d]: got %h expected 2af3", i, act_data[0]); end
      n_cmp++; if (act_rdy[0] !== 1'b0) begin n_err++; $display("FAIL clr_ready[%0d]: got %b expected 0", i, act_rdy[0]); end
      if (i == 0) begin
        n_cmp++; if (act_we[2] !== 4'b0000) begin n_err++; $display("FAIL noclear_we: got %b expected 0000", act_we[2]); end
      end
      advance();
    end
    #1;
    n_cmp++; if (act_rdy[0] !== 1'b1) begin n_err++; $display("FAIL clr_done_ready: got %b expected 1", act_rdy[0]); end
  endtask

  task automatic test_raster_write();
    set_in(0, 0, 0, 1, 1, 2, 14'h1234); #1;
    n_cmp++; if (act_we[0] !== 4'b0001) begin n_err++; $display("FAIL wr_we: got %b expected 0001", act_we[0]); end
    n_cmp++; if (act_addr[0] !== 3'd5) begin n_err++; $display("FAIL wr_addr: got %0d expected 5", act_addr[0]); end
    n_cmp++; if (act_data[0] !== 14'h1234) begin n_err++; $display("FAIL wr_data: got %h expected 1234", act_data[0]); end
    advance();
    we = 1'b0; #1;
    n_cmp++; if (act_we[0] !== 4'b0000) begin n_err++; $display("FAIL wr_idle_we: got %b expected 0000", act_we[0]); end
    advance();
  endtask

  task automatic test_frame_done_n3();
    pulse_fd(0);
    for (int i = 0; i < PIX; i++) begin
      set_in(0, 0, 0, 1, 0, 1, 14'h0F0); #1;
      n_cmp++; if (act_r[0] !== 2'd2) begin n_err++; $display("FAIL fd_target: got %0d expected 2", act_r[0]); end
      n_cmp++; if (act_we[0] !== 4'b0100) begin n_err++; $display("FAIL fd_clr_we[%0d]: got %b expected 0100", i, act_we[0]); end
      n_cmp++; if (act_addr[0] !== 3'(i)) begin n_err++; $display("FAIL fd_clr_addr[%0d]: got %0d expected %0d", i, act_addr[0], i); end
      advance();
    end
    we = 1'b0; vs = 1'b1; #1;
    advance();
    vs = 1'b0; #1;
    n_cmp++; if (act_d[0] !== 2'd0) begin n_err++; $display("FAIL vs_display: got %0d expected 0", act_d[0]); end
    n_cmp++; if (act_swap[0] !== 1'b1) begin n_err++; $display("FAIL vs_swap: got %b expected 1", act_swap[0]); end
    advance(); #1;
    n_cmp++; if (act_swap[0] !== 1'b0) begin n_err++; $display("FAIL vs_swap_pulse: got %b expected 0", act_swap[0]); end
    vs = 1'b1; #1;
    advance();
    vs = 1'b0; #1;
    n_cmp++; if (act_swap[0] !== 1'b0) begin n_err++; $display("FAIL vs_empty_swap: got %b expected 0", act_swap[0]); end
    n_cmp++; if (act_d[0] !== 2'd0) begin n_err++; $display("FAIL vs_empty_display: got %0d expected 0", act_d[0]); end
  endtask

  task automatic test_drops();
    do_reset();
    wait_ready(); pulse_fd(0);
    wait_ready(); pulse_fd(0);
    #1;
    n_cmp++; if (act_drop[0] !== 8'd1) begin n_err++; $display("FAIL drop_one: got %0d expected 1", act_drop[0]); end
    n_cmp++; if (act_r[0] !== 2'd0) begin n_err++; $display("FAIL drop_target: got %0d expected 0", act_r[0]); end
    vs = 1'b1; #1;
    advance();
    vs = 1'b0; #1;
    n_cmp++; if (act_d[0] !== 2'd2) begin n_err++; $display("FAIL drop_display: got %0d expected 2", act_d[0]); end
    for (int i = 0; i < 300; i++) begin wait_ready(); pulse_fd(0); end
    #1;
    n_cmp++; if (act_drop[0] !== 8'd255) begin n_err++; $display("FAIL drop_saturate: got %0d expected 255", act_drop[0]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    wait_ready(); pulse_fd(0);
    wait_ready(); pulse_fd(1);
    #1;
    n_cmp++; if (act_d[0] !== 2'd2) begin n_err++; $display("FAIL sim_display: got %0d expected 2", act_d[0]); end
    n_cmp++; if (act_swap[0] !== 1'b1) begin n_err++; $display("FAIL sim_swap: got %b expected 1", act_swap[0]); end
    n_cmp++; if (act_drop[0] !== 8'd1) begin n_err++; $display("FAIL sim_drop: got %0d expected 1", act_drop[0]); end
    n_cmp++; if (act_r[0] !== 2'd0) begin n_err++; $display("FAIL sim_target: got %0d expected 0", act_r[0]); end
    n_cmp++; if (act_rdy[0] !== 1'b0) begin n_err++; $display("FAIL sim_ready: got %b expected 0", act_rdy[0]); end
    advance(); advance(); #1;
    n_cmp++; if (act_addr[0] !== 3'd2) begin n_err++; $display("FAIL midclr_addr: got %0d expected 2", act_addr[0]); end
    rst = 1'b1; #1;
    advance();
    rst = 1'b0; #1;
    n_cmp++; if (act_r[0] !== 2'd0) begin n_err++; $display("FAIL midrst_target: got %0d expected 0", act_r[0]); end
    n_cmp++; if (act_d[0] !== 2'd1) begin n_err++; $display("FAIL midrst_display: got %0d expected 1", act_d[0]); end
    n_cmp++; if (act_addr[0] !== 3'd0) begin n_err++; $display("FAIL midrst_addr: got %0d expected 0", act_addr[0]); end
    n_cmp++; if (act_we[0] !== 4'b0001) begin n_err++; $display("FAIL midrst_we: got %b expected 0001", act_we[0]); end
    n_cmp++; if (act_drop[0] !== 8'd0) begin n_err++; $display("FAIL midrst_drop: got %0d expected 0", act_drop[0]); end
  endtask

  task automatic test_n2_wait_vsync();
    do_reset();
    wait_ready(); pulse_fd(0);
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 2), $urandom); #1;
      n_cmp++; if (act_we[1] !== 4'b0000) begin n_err++; $display("FAIL n2_wait_we[%0d]: got %b expected 0000", i, act_we[1]); end
      n_cmp++; if (act_rdy[1] !== 1'b0) begin n_err++; $display("FAIL n2_wait_ready[%0d]: got %b expected 0", i, act_rdy[1]); end
      advance();
    end
    we = 1'b0; vs = 1'b1; #1;
    advance();
    vs = 1'b0; #1;
    n_cmp++; if (act_d[1] !== 2'd0) begin n_err++; $display("FAIL n2_display: got %0d expected 0", act_d[1]); end
    n_cmp++; if (act_r[1] !== 2'd1) begin n_err++; $display("FAIL n2_target: got %0d expected 1", act_r[1]); end
    n_cmp++; if (act_swap[1] !== 1'b1) begin n_err++; $display("FAIL n2_swap: got %b expected 1", act_swap[1]); end
    n_cmp++; if (act_we[1] !== 4'b0010) begin n_err++; $display("FAIL n2_clr_we: got %b expected 0010", act_we[1]); end
    n_cmp++; if (act_data[1] !== 14'h1697) begin n_err++; $display("FAIL n2_clr_data: got %h expected 1697", act_data[1]); end
    advance(); #1;
    n_cmp++; if (act_swap[1] !== 1'b0) begin n_err++; $display("FAIL n2_swap_pulse: got %b expected 0", act_swap[1]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      set_in($urandom_range(0, 999) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
      #1;
      for (int k = 0; k < NI; k++) begin
        int ew;
        ew = exp_we(m[k], we);
        n_cmp++; if (act_we[k] !== 4'(ew)) begin n_err++; $display("FAIL rnd_we[%0d] cyc %0d: got %b expected %b", k, cyc, act_we[k], 4'(ew)); end
        if (ew != 0) begin
          n_cmp++; if (act_addr[k] !== 3'(exp_addr(m[k], vert, horiz))) begin n_err++; $display("FAIL rnd_addr[%0d] cyc %0d: got %0d expected %0d", k, cyc, act_addr[k], exp_addr(m[k], vert, horiz)); end
          n_cmp++; if (act_data[k] !== DW'(exp_data(m[k], din))) begin n_err++; $display("FAIL rnd_data[%0d] cyc %0d: got %h expected %h", k, cyc, act_data[k], DW'(exp_data(m[k], din))); end
        end
        n_cmp++; if (act_r[k] !== 2'(m[k].r)) begin n_err++; $display("FAIL rnd_target[%0d] cyc %0d: got %0d expected %0d", k, cyc, act_r[k], m[k].r); end
        n_cmp++; if (act_d[k] !== 2'(m[k].d)) begin n_err++; $display("FAIL rnd_display[%0d] cyc %0d: got %0d expected %0d", k, cyc, act_d[k], m[k].d); end
        n_cmp++; if (act_rdy[k] !== (m[k].phase == PH_DRAW)) begin n_err++; $display("FAIL rnd_ready[%0d] cyc %0d: got %b expected %b", k, cyc, act_rdy[k], m[k].phase == PH_DRAW); end
        n_cmp++; if (act_swap[k] !== m[k].swap) begin n_err++; $display("FAIL rnd_swap[%0d] cyc %0d: got %b expected %b", k, cyc, act_swap[k], m[k].swap); end
        n_cmp++; if (act_drop[k] !== 8'(m[k].drops)) begin n_err++; $display("FAIL rnd_drop[%0d] cyc %0d: got %0d expected %0d", k, cyc, act_drop[k], m[k].drops); end
      end
      advance();
    end
  endtask

  initial begin
    m[0].n = 3; m[0].ce = 1; m[0].cc = 'hABC;
    m[1].n = 2; m[1].ce = 1; m[1].cc = 'h5A5;
    m[2].n = 4; m[2].ce = 0; m[2].cc = 'h123;
    for (int k = 0; k < NI; k++) m[k] = mdl_reset(m[k]);
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_clear();
    test_raster_write();
    test_frame_done_n3();
    test_drops();
    test_simultaneous();
    test_n2_wait_vsync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
